instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the control unit. Holds the PC and fetches 32-bit words over a req/ack memory port.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/instr_fetch_unit_pc_next_logic.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the control unit:
// fetch state encoding, opcode constants and instruction field slices.
package cpu_pkg;

    localparam int OPCODE_W = 6;

    // Fetch stage sequencing
    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_FETCH = 2'b01,
        FS_VALID = 2'b10
    } fetch_state_e;

    // Opcodes decoded by the control unit
    localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_JR   = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNEQ = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_BGEZ = 6'h01;

    // Opcode field, instr[31:26]
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] word);
        return word[31:26];
    endfunction

    // Branch immediate, instr[15:0]
    function automatic logic [15:0] get_imm16(input logic [31:0] word);
        return word[15:0];
    endfunction

    // Jump index, instr[25:0]
    function automatic logic [25:0] get_index26(input logic [31:0] word);
        return word[25:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// Combinational next-PC selection for the fetch stage. Priority:
// JR target, then J-type target, then taken branch, then sequential.
// A target whose low two bits are non-zero is word-aligned and flagged.
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       index26,
    input  logic [15:0]       imm16,
    input  logic              jump,
    input  logic              jr_sel,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              branch,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] raw_target_s;
    logic [ADDR_W-1:0] jump_target_s;
    logic [ADDR_W-1:0] branch_offset_s;

    // Jump target keeps the top bits of the sequential PC; branch offset is a sign-extended word offset
    assign jump_target_s   = {pc_plus4[ADDR_W-1:28], index26, 2'b00};
    assign branch_offset_s = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    // Select the redirect target in priority order and word-align it
    always_comb begin
        raw_target_s = pc_plus4;
        if (jump && jr_sel) begin
            raw_target_s = jr_target;
        end else if (jump) begin
            raw_target_s = jump_target_s;
        end else if (branch && branch_taken) begin
            raw_target_s = pc_plus4 + branch_offset_s;
        end else begin
            raw_target_s = pc_plus4;
        end
        misaligned = (raw_target_s[1:0] != 2'b00);
        next_pc    = {raw_target_s[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per request over a
// req/ack port, presents it to the control unit, and advances the PC on retire.
// Optional feature macro: IFU_PERF_CNT_EN adds retire and fetch-wait counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    input  logic                instr_ready,
    input  logic                jump,
    input  logic                jr_sel,
    input  logic [ADDR_W-1:0]   jr_target,
    input  logic                branch,
    input  logic                branch_taken,
    output logic                addr_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_wait_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               imem_req_q, imem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               addr_err_q, addr_err_d;

    logic               retire_s;
    logic [ADDR_W-1:0]  pc_plus4_s;
    logic [ADDR_W-1:0]  next_pc_s;
    logic               misaligned_s;

    assign pc_plus4_s = pc_q + PC_STEP;
    assign retire_s   = (state_q == FS_VALID) && instr_ready;

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_plus4     (pc_plus4_s),
        .index26      (get_index26(instr_q)),
        .imm16        (get_imm16(instr_q)),
        .jump         (jump),
        .jr_sel       (jr_sel),
        .jr_target    (jr_target),
        .branch       (branch),
        .branch_taken (branch_taken),
        .next_pc      (next_pc_s),
        .misaligned   (misaligned_s)
    );

    // Fetch sequencing: next state, captured instruction, PC update and sticky error
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
            end
            FS_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = FS_VALID;
                end else begin
                    state_d = FS_FETCH;
                end
            end
            FS_VALID: begin
                if (instr_ready) begin
                    pc_d       = next_pc_s;
                    addr_err_d = addr_err_q | misaligned_s;
                    state_d    = FS_FETCH;
                end else begin
                    state_d = FS_VALID;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        // Port strobes are registered copies of the next-state decode
        imem_req_d    = (state_d == FS_FETCH);
        instr_valid_d = (state_d == FS_VALID);
    end

    // Fetch state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= {INSTR_W{1'b0}};
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = get_opcode(instr_q);
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign addr_err    = addr_err_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;

    // Counters: retired instructions and fetch cycles spent waiting for ack
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_wait_cnt_d  = perf_wait_cnt_q;
        if (retire_s) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end else begin
            perf_fetch_cnt_d = perf_fetch_cnt_q;
        end
        if ((state_q == FS_FETCH) && !imem_ack) begin
            perf_wait_cnt_d = perf_wait_cnt_q + 32'd1;
        end else begin
            perf_wait_cnt_d = perf_wait_cnt_q;
        end
    end

    // Counter registers, cleared by reset and wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt_q <= 32'd0;
            perf_wait_cnt_q  <= 32'd0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_wait_cnt_q  <= perf_wait_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_wait_cnt  = perf_wait_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized fetch/retire traffic checked against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic        jump;
    logic        jr_sel;
    logic [31:0] jr_target;
    logic        branch;
    logic        branch_taken;
    logic        addr_err;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cur;
    logic        m_err;
    int          m_retires;
    int          m_waits;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_ready  (instr_ready),
        .jump         (jump),
        .jr_sel       (jr_sel),
        .jr_target    (jr_target),
        .branch       (branch),
        .branch_taken (branch_taken),
        .addr_err     (addr_err)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule, returns {misaligned, aligned_target}
    function automatic logic [32:0] model_next(input logic [31:0] cur_pc, input logic [31:0] w,
                                               input logic j, input logic jrs, input logic [31:0] jt,
                                               input logic b, input logic bt);
        logic [31:0] p4;
        logic [31:0] t;
        logic [15:0] imm;
        int          off;
        p4 = cur_pc + 32'd4;
        if (j && jrs) begin
            t = jt;
        end else if (j) begin
            t = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        end else if (b && bt) begin
            imm = w[15:0];
            off = int'($signed(imm)) * 4;
            t   = p4 + 32'(off);
        end else begin
            t = p4;
        end
        return {(t % 32'd4) != 32'd0, t - (t % 32'd4)};
    endfunction

    task automatic wait_req();
        int k = 0;
        while (imem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_seen", 32'(imem_req), 32'd1);
    endtask

    // One fetch with a given number of no-ack cycles before the ack
    task automatic fetch(input int waits, input logic [31:0] word);
        wait_req();
        check_eq("fetch_addr", imem_addr, m_pc);
        check_eq("valid_low_in_fetch", 32'(instr_valid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check_eq("req_hold", 32'(imem_req), 32'd1);
            check_eq("addr_hold", imem_addr, m_pc);
            m_waits++;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_cur      = word;
        check_eq("instr_valid", 32'(instr_valid), 32'd1);
        check_eq("req_off_in_valid", 32'(imem_req), 32'd0);
        check_eq("instr", instr, word);
        check_eq("opcode", 32'(opcode), 32'(word >> 26));
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    // Hold VALID for some cycles with ignored noise, then retire with the given redirect
    task automatic retire(input int stall, input logic j, input logic jrs, input logic [31:0] jt,
                          input logic b, input logic bt);
        logic [32:0] nx;
        for (int i = 0; i < stall; i++) begin
            instr_ready  = 1'b0;
            imem_ack     = 1'($urandom);
            imem_rdata   = $urandom;
            jump         = 1'($urandom);
            jr_sel       = 1'($urandom);
            jr_target    = $urandom;
            branch       = 1'($urandom);
            branch_taken = 1'($urandom);
            @(negedge clk);
            check_eq("valid_hold", 32'(instr_valid), 32'd1);
            check_eq("instr_hold", instr, m_cur);
            check_eq("pc_hold", pc, m_pc);
        end
        imem_ack     = 1'b0;
        jump         = j;
        jr_sel       = jrs;
        jr_target    = jt;
        branch       = b;
        branch_taken = bt;
        instr_ready  = 1'b1;
        nx = model_next(m_pc, m_cur, j, jrs, jt, b, bt);
        m_pc  = nx[31:0];
        m_err = m_err | nx[32];
        m_retires++;
        @(negedge clk);
        instr_ready  = 1'b0;
        jump         = 1'b0;
        jr_sel       = 1'b0;
        branch       = 1'b0;
        branch_taken = 1'b0;
        check_eq("valid_off_after_retire", 32'(instr_valid), 32'd0);
        check_eq("req_after_retire", 32'(imem_req), 32'd1);
        check_eq("next_addr", imem_addr, m_pc);
        check_eq("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    task automatic set_pc(input logic [31:0] target);
        fetch(0, $urandom);
        retire(0, 1'b1, 1'b1, target, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] jt;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        jump = 1'b0; jr_sel = 1'b0; jr_target = 32'd0; branch = 1'b0; branch_taken = 1'b0;
        m_pc = 32'd0; m_cur = 32'd0; m_err = 1'b0; m_retires = 0; m_waits = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;

        // Test 1: first fetch at reset PC with two wait cycles
        fetch(2, 32'h8C12_3456);
        check_eq("t1_addr", pc, 32'h0000_0000);
        retire(1, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        // Test 2: sequential
        fetch(0, $urandom);
        retire(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("t2_seq", imem_addr, 32'h0000_0014);
        // Test 3: branch -1 word, taken and not taken
        set_pc(32'h0000_0020);
        w = 32'h1000_FFFF;
        fetch(1, w);
        retire(0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("t3_taken", imem_addr, 32'h0000_0020);
        fetch(0, w);
        retire(0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t3_not_taken", imem_addr, 32'h0000_0024);
        // Test 4: J-type with a taken branch alongside, then misaligned JR
        set_pc(32'h1000_0000);
        fetch(0, 32'h0800_0100);
        retire(0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("t4_jump", imem_addr, 32'h1000_0400);
        fetch(0, $urandom);
        retire(0, 1'b1, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
        check_eq("t4_jr_align", imem_addr, 32'h0000_0040);
        check_eq("t4_err", 32'(addr_err), 32'd1);
        // Test 5: wrap of the PC
        set_pc(32'hFFFF_FFFC);
        fetch(0, $urandom);
        retire(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("t5_wrap", imem_addr, 32'h0000_0000);

        // Test 5b: reset during FETCH with a late ack
        set_pc(32'h0000_0100);
        wait_req();
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("midrst_req", 32'(imem_req), 32'd0);
        check_eq("midrst_pc", pc, 32'h0000_0000);
        check_eq("midrst_valid", 32'(instr_valid), 32'd0);
        check_eq("midrst_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("late_ack_valid", 32'(instr_valid), 32'd0);
        check_eq("late_ack_instr", instr, 32'd0);
        m_pc = 32'd0; m_err = 1'b0; m_retires = 0; m_waits = 0;

        // Test 6: three retires with four wait cycles in total
        fetch(1, $urandom); retire(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        fetch(2, $urandom); retire(1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        fetch(1, $urandom); retire(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check_eq("t6_fetch_cnt", perf_fetch_cnt, 32'd3);
        check_eq("t6_wait_cnt", perf_wait_cnt, 32'd4);
`endif

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            jt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fetch($urandom_range(0, 3), $urandom);
            retire($urandom_range(0, 2), 1'($urandom), 1'($urandom), jt,
                   1'($urandom), 1'($urandom));
        end
`ifdef IFU_PERF_CNT_EN
        check_eq("rand_fetch_cnt", perf_fetch_cnt, 32'(m_retires));
        check_eq("rand_wait_cnt", perf_wait_cnt, 32'(m_waits));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
